mms_stream_ctrl: RTL and testbench



---
 rtl/mms_stream_if.sv | 38 +++
 rtl/mms_stream_ctrl.sv | 156 +++++++++++++++
 tb/tb_mms_stream_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mms_stream_if.sv
// Stream bundle for mms_stream_ctrl: number source (valid/ready) and result sink (valid/ready).
// MMS_INDEX_EN adds result_idx, the 0-based position of the winning number in its frame.
interface mms_stream_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] number;
    logic          select;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          frame_sel;
`ifdef MMS_INDEX_EN
    logic [CNT_W-1:0] result_idx;

    modport slave (
        input  in_valid, number, select, out_ready,
        output in_ready, out_valid, result, frame_sel, result_idx
    );

    modport master (
        output in_valid, number, select, out_ready,
        input  in_ready, out_valid, result, frame_sel, result_idx
    );
`else
    modport slave (
        input  in_valid, number, select, out_ready,
        output in_ready, out_valid, result, frame_sel
    );

    modport master (
        output in_valid, number, select, out_ready,
        input  in_ready, out_valid, result, frame_sel
    );
`endif
endinterface

// File: rtl/mms_stream_ctrl.sv
// Sequential max/min scheduler: folds FRAME_LEN serial numbers through one comparator per frame.
// Optional macro MMS_INDEX_EN adds result_idx (position of the winner, earliest on ties).
module mms_stream_ctrl #(
    parameter int DW        = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    mms_stream_if.slave  s
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // One extra bit so FRAME_LEN == 2^CNT_W is still reachable by cnt + 1.
    localparam logic [CNT_W:0] FRAME_LEN_W = (CNT_W+1)'(FRAME_LEN);
    localparam logic [CNT_W:0] ONE_W       = (CNT_W+1)'(1);

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [DW-1:0]    best_q,      best_d;
    logic             sel_q,       sel_d;
    logic [DW-1:0]    result_q,    result_d;
    logic             frame_sel_q, frame_sel_d;
    logic             out_valid_q, out_valid_d;
`ifdef MMS_INDEX_EN
    logic [CNT_W-1:0] best_idx_q,   best_idx_d;
    logic [CNT_W-1:0] result_idx_q, result_idx_d;
`endif

    logic             in_ready;
    logic             beat;
    logic             take;
    logic             load_first;
    logic [CNT_W:0]   cnt_inc;
    logic [DW-1:0]    new_best;

    assign in_ready = (state_q == DONE) ? s.out_ready : 1'b1;
    assign beat     = s.in_valid && in_ready;
    // Strict compares: a tie never replaces the earlier value.
    assign take     = sel_q ? (s.number < best_q) : (s.number > best_q);
    assign new_best = take ? s.number : best_q;
    assign cnt_inc  = {1'b0, cnt_q} + ONE_W;

    // NOTE: every *_d gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        best_d      = best_q;
        sel_d       = sel_q;
        result_d    = result_q;
        frame_sel_d = frame_sel_q;
        out_valid_d = out_valid_q;
        load_first  = 1'b0;
`ifdef MMS_INDEX_EN
        best_idx_d   = best_idx_q;
        result_idx_d = result_idx_q;
`endif

        case (state_q)
            IDLE: begin
                load_first = beat;
            end
            ACCUM: begin
                if (beat) begin
                    best_d = new_best;
`ifdef MMS_INDEX_EN
                    if (take) best_idx_d = cnt_q;
`endif
                    if (cnt_inc == FRAME_LEN_W) begin
                        result_d    = new_best;
                        frame_sel_d = sel_q;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = DONE;
`ifdef MMS_INDEX_EN
                        result_idx_d = take ? cnt_q : best_idx_q;
`endif
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            DONE: begin
                // in_ready follows out_ready here, so a beat implies the result is consumed.
                if (s.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    load_first  = beat;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load_first) begin
            best_d  = s.number;
            sel_d   = s.select;
            cnt_d   = (CNT_W)'(1);
            state_d = ACCUM;
`ifdef MMS_INDEX_EN
            best_idx_d = '0;
`endif
        end

        // Abort wins over everything; result, frame_sel and result_idx keep their last values.
        if (clear) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments and all reset to known values, asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            best_q      <= '0;
            sel_q       <= 1'b0;
            result_q    <= '0;
            frame_sel_q <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MMS_INDEX_EN
            best_idx_q   <= '0;
            result_idx_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_q      <= best_d;
            sel_q       <= sel_d;
            result_q    <= result_d;
            frame_sel_q <= frame_sel_d;
            out_valid_q <= out_valid_d;
`ifdef MMS_INDEX_EN
            best_idx_q   <= best_idx_d;
            result_idx_q <= result_idx_d;
`endif
        end
    end

    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid_q;
    assign s.result    = result_q;
    assign s.frame_sel = frame_sel_q;
`ifdef MMS_INDEX_EN
    assign s.result_idx = result_idx_q;
`endif

endmodule

// File: tb/tb_mms_stream_ctrl.sv
// Directed self-checking bench for mms_stream_ctrl (FRAME_LEN=4, DW=8).
// Index checks are compiled in only when MMS_INDEX_EN is defined.
module tb_mms_stream_ctrl;

    logic clk;
    logic rst_n;
    logic clear;
    int   pass_cnt;
    int   total_cnt;

    mms_stream_if #(.DW(8), .CNT_W(8)) s_if ();

    mms_stream_ctrl #(.DW(8), .FRAME_LEN(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .s     (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat for one clock; return 1 time unit after the edge.
    task automatic drive_beat(input logic [7:0] num, input logic sel);
        s_if.in_valid = 1'b1;
        s_if.number   = num;
        s_if.select   = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        s_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (s_if.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", s_if.in_ready); else pass_cnt++;
        total_cnt++; if (s_if.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", s_if.out_valid); else pass_cnt++;
        total_cnt++; if (s_if.result !== 8'd0) $display("FAIL reset_result got=%0d exp=0", s_if.result); else pass_cnt++;
        total_cnt++; if (s_if.frame_sel !== 1'b0) $display("FAIL reset_frame_sel got=%b exp=0", s_if.frame_sel); else pass_cnt++;
`ifdef MMS_INDEX_EN
        total_cnt++; if (s_if.result_idx !== 8'd0) $display("FAIL reset_idx got=%0d exp=0", s_if.result_idx); else pass_cnt++;
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_max_basic();
        s_if.out_ready = 1'b1;
        drive_beat(8'd12, 1'b0);
        drive_beat(8'd200, 1'b0);
        drive_beat(8'd7, 1'b0);
        total_cnt++; if (s_if.out_valid !== 1'b0) $display("FAIL max_early_valid got=%b exp=0", s_if.out_valid); else pass_cnt++;
        drive_beat(8'd200, 1'b0);
        total_cnt++; if (s_if.out_valid !== 1'b1) $display("FAIL max_valid got=%b exp=1", s_if.out_valid); else pass_cnt++;
        total_cnt++; if (s_if.result !== 8'd200) $display("FAIL max_result got=%0d exp=200", s_if.result); else pass_cnt++;
        total_cnt++; if (s_if.frame_sel !== 1'b0) $display("FAIL max_frame_sel got=%b exp=0", s_if.frame_sel); else pass_cnt++;
`ifdef MMS_INDEX_EN
        total_cnt++; if (s_if.result_idx !== 8'd1) $display("FAIL max_idx got=%0d exp=1", s_if.result_idx); else pass_cnt++;
`endif
        idle_cycle();
        total_cnt++; if (s_if.out_valid !== 1'b0) $display("FAIL max_consumed got=%b exp=0", s_if.out_valid); else pass_cnt++;
        total_cnt++; if (s_if.in_ready !== 1'b1) $display("FAIL max_idle_ready got=%b exp=1", s_if.in_ready); else pass_cnt++;
    endtask

    task automatic test_min_select_lock();
        drive_beat(8'd50, 1'b1);
        drive_beat(8'd3, 1'b0);
        drive_beat(8'd3, 1'b0);
        drive_beat(8'd90, 1'b0);
        total_cnt++; if (s_if.out_valid !== 1'b1) $display("FAIL min_valid got=%b exp=1", s_if.out_valid); else pass_cnt++;
        total_cnt++; if (s_if.result !== 8'd3) $display("FAIL min_result got=%0d exp=3", s_if.result); else pass_cnt++;
        total_cnt++; if (s_if.frame_sel !== 1'b1) $display("FAIL min_frame_sel got=%b exp=1", s_if.frame_sel); else pass_cnt++;
`ifdef MMS_INDEX_EN
        total_cnt++; if (s_if.result_idx !== 8'd1) $display("FAIL min_idx got=%0d exp=1", s_if.result_idx); else pass_cnt++;
`endif
        idle_cycle();
    endtask

    task automatic test_stall();
        s_if.out_ready = 1'b0;
        drive_beat(8'd9, 1'b0);
        drive_beat(8'd8, 1'b0);
        drive_beat(8'd7, 1'b0);
        drive_beat(8'd6, 1'b0);
        s_if.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (s_if.out_valid !== 1'b1) $display("FAIL stall_valid cyc=%0d got=%b exp=1", i, s_if.out_valid); else pass_cnt++;
            total_cnt++; if (s_if.result !== 8'd9) $display("FAIL stall_result cyc=%0d got=%0d exp=9", i, s_if.result); else pass_cnt++;
            total_cnt++; if (s_if.in_ready !== 1'b0) $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, s_if.in_ready); else pass_cnt++;
            @(posedge clk);
            #1;
        end
        s_if.out_ready = 1'b1;
        s_if.in_valid  = 1'b1;
        s_if.number    = 8'd255;
        s_if.select    = 1'b0;
        #1;
        total_cnt++; if (s_if.in_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", s_if.in_ready); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++; if (s_if.out_valid !== 1'b0) $display("FAIL release_consumed got=%b exp=0", s_if.out_valid); else pass_cnt++;
        drive_beat(8'd1, 1'b0);
        drive_beat(8'd2, 1'b0);
        total_cnt++; if (s_if.out_valid !== 1'b0) $display("FAIL overlap_early got=%b exp=0", s_if.out_valid); else pass_cnt++;
        drive_beat(8'd3, 1'b0);
        total_cnt++; if (s_if.out_valid !== 1'b1) $display("FAIL overlap_valid got=%b exp=1", s_if.out_valid); else pass_cnt++;
        total_cnt++; if (s_if.result !== 8'd255) $display("FAIL overlap_result got=%0d exp=255", s_if.result); else pass_cnt++;
`ifdef MMS_INDEX_EN
        total_cnt++; if (s_if.result_idx !== 8'd0) $display("FAIL overlap_idx got=%0d exp=0", s_if.result_idx); else pass_cnt++;
`endif
        idle_cycle();
    endtask

    task automatic test_gaps();
        logic       vld [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] num [7] = '{8'd4, 8'h80, 8'h81, 8'd1, 8'h82, 8'd2, 8'hFF};
        for (int i = 0; i < 7; i++) begin
            s_if.in_valid = vld[i];
            s_if.number   = num[i];
            s_if.select   = 1'b0;
            @(posedge clk);
            #1;
            if (i < 6) begin
                total_cnt++; if (s_if.out_valid !== 1'b0) $display("FAIL gap_early cyc=%0d got=%b exp=0", i, s_if.out_valid); else pass_cnt++;
            end
        end
        total_cnt++; if (s_if.out_valid !== 1'b1) $display("FAIL gap_valid got=%b exp=1", s_if.out_valid); else pass_cnt++;
        total_cnt++; if (s_if.result !== 8'hFF) $display("FAIL gap_result got=%0h exp=ff", s_if.result); else pass_cnt++;
`ifdef MMS_INDEX_EN
        total_cnt++; if (s_if.result_idx !== 8'd3) $display("FAIL gap_idx got=%0d exp=3", s_if.result_idx); else pass_cnt++;
`endif
        idle_cycle();
    endtask

    task automatic test_clear();
        drive_beat(8'd10, 1'b0);
        drive_beat(8'd20, 1'b0);
        clear         = 1'b1;
        s_if.in_valid = 1'b1;
        s_if.number   = 8'd99;
        @(posedge clk);
        #1;
        clear = 1'b0;
        total_cnt++; if (s_if.out_valid !== 1'b0) $display("FAIL clear_valid got=%b exp=0", s_if.out_valid); else pass_cnt++;
        total_cnt++; if (s_if.result !== 8'hFF) $display("FAIL clear_result_hold got=%0h exp=ff", s_if.result); else pass_cnt++;
`ifdef MMS_INDEX_EN
        total_cnt++; if (s_if.result_idx !== 8'd3) $display("FAIL clear_idx_hold got=%0d exp=3", s_if.result_idx); else pass_cnt++;
`endif
        for (int i = 1; i <= 3; i++) begin
            drive_beat(8'(i), 1'b0);
            total_cnt++; if (s_if.out_valid !== 1'b0) $display("FAIL clear_early beat=%0d got=%b exp=0", i, s_if.out_valid); else pass_cnt++;
        end
        drive_beat(8'd4, 1'b0);
        total_cnt++; if (s_if.out_valid !== 1'b1) $display("FAIL clear_frame_valid got=%b exp=1", s_if.out_valid); else pass_cnt++;
        total_cnt++; if (s_if.result !== 8'd4) $display("FAIL clear_frame_result got=%0d exp=4", s_if.result); else pass_cnt++;
`ifdef MMS_INDEX_EN
        total_cnt++; if (s_if.result_idx !== 8'd3) $display("FAIL clear_frame_idx got=%0d exp=3", s_if.result_idx); else pass_cnt++;
`endif
        idle_cycle();
        total_cnt++; if (s_if.out_valid !== 1'b0) $display("FAIL clear_single_pulse got=%b exp=0", s_if.out_valid); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        s_if.out_ready = 1'b0;
        drive_beat(8'd5, 1'b1);
        drive_beat(8'd6, 1'b1);
        drive_beat(8'd7, 1'b1);
        drive_beat(8'd8, 1'b1);
        s_if.in_valid = 1'b0;
        total_cnt++; if (s_if.out_valid !== 1'b1) $display("FAIL pre_reset_valid got=%b exp=1", s_if.out_valid); else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (s_if.out_valid !== 1'b0) $display("FAIL areset_valid got=%b exp=0", s_if.out_valid); else pass_cnt++;
        total_cnt++; if (s_if.result !== 8'd0) $display("FAIL areset_result got=%0d exp=0", s_if.result); else pass_cnt++;
        total_cnt++; if (s_if.in_ready !== 1'b1) $display("FAIL areset_in_ready got=%b exp=1", s_if.in_ready); else pass_cnt++;
        total_cnt++; if (s_if.frame_sel !== 1'b0) $display("FAIL areset_frame_sel got=%b exp=0", s_if.frame_sel); else pass_cnt++;
`ifdef MMS_INDEX_EN
        total_cnt++; if (s_if.result_idx !== 8'd0) $display("FAIL areset_idx got=%0d exp=0", s_if.result_idx); else pass_cnt++;
`endif
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s_if.out_ready = 1'b1;
        drive_beat(8'd30, 1'b1);
        drive_beat(8'd40, 1'b0);
        drive_beat(8'd10, 1'b0);
        drive_beat(8'd20, 1'b0);
        total_cnt++; if (s_if.out_valid !== 1'b1) $display("FAIL post_reset_valid got=%b exp=1", s_if.out_valid); else pass_cnt++;
        total_cnt++; if (s_if.result !== 8'd10) $display("FAIL post_reset_result got=%0d exp=10", s_if.result); else pass_cnt++;
        total_cnt++; if (s_if.frame_sel !== 1'b1) $display("FAIL post_reset_frame_sel got=%b exp=1", s_if.frame_sel); else pass_cnt++;
`ifdef MMS_INDEX_EN
        total_cnt++; if (s_if.result_idx !== 8'd2) $display("FAIL post_reset_idx got=%0d exp=2", s_if.result_idx); else pass_cnt++;
`endif
        idle_cycle();
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        rst_n          = 1'b0;
        clear          = 1'b0;
        s_if.in_valid  = 1'b0;
        s_if.number    = '0;
        s_if.select    = 1'b0;
        s_if.out_ready = 1'b1;

        test_reset();
        test_max_basic();
        test_min_select_lock();
        test_stall();
        test_gaps();
        test_clear();
        test_async_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
